// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: AW channel field widths and the allocator FSM state type.
package axi_node_pkg;

  localparam int AXI_LEN_W    = 8;
  localparam int AXI_SIZE_W   = 3;
  localparam int AXI_BURST_W  = 2;
  localparam int AXI_CACHE_W  = 4;
  localparam int AXI_PROT_W   = 3;
  localparam int AXI_REGION_W = 4;
  localparam int AXI_QOS_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } aw_state_e;

endpackage

// File: rtl/axi_aw_rr_arbiter.sv
// Round-robin request search starting at a stored pointer; pointer advances past the
// index reported on upd_i.
module axi_aw_rr_arbiter #(
  parameter int N_REQ = 7,
  parameter int LOG_N = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             upd_i,
  input  logic [LOG_N-1:0] upd_idx_i,
  output logic [LOG_N-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [LOG_N-1:0] rr_q, rr_d;

  always_comb begin
    int k;
    logic [LOG_N-1:0] k_idx;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    k           = 0;
    k_idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      k_idx = LOG_N'(k);
      if (!gnt_valid_o && req_i[k_idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = k_idx;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (upd_i) begin
      rr_d = (upd_idx_i == LOG_N'(N_REQ-1)) ? '0 : upd_idx_i + LOG_N'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/axi_multiplexer.sv
// Generic N-input, binary-select data multiplexer over a flattened input bus.
module axi_multiplexer #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 4,
  parameter int SEL_WIDTH  = $clog2(N_IN)
) (
  input  logic [N_IN*DATA_WIDTH-1:0] data_i,
  input  logic [SEL_WIDTH-1:0]       sel_i,
  output logic [DATA_WIDTH-1:0]      data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_i == SEL_WIDTH'(i)) begin
        data_o = data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/axi_aw_allocator.sv
// AW channel allocator: round-robin selection of one target port, routed to the master
// side, with a push of the winner ID into the write-data allocator FIFO on each handshake.
//
// state   | meaning
// IDLE    | free arbitration; only offers an AW when the ID FIFO has room
// HOLD    | winner offered but not accepted; winner frozen until handshake
module axi_aw_allocator
  import axi_node_pkg::*;
#(
  parameter int AXI_ADDRESS_W = 32,
  parameter int AXI_USER_W    = 6,
  parameter int N_TARG_PORT   = 7,
  parameter int LOG_N_TARG    = $clog2(N_TARG_PORT),
  parameter int AXI_ID_IN     = 16,
  parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG
) (
  input  logic                                   clk,
  input  logic                                   rst_n,

  input  logic [N_TARG_PORT*AXI_ID_IN-1:0]       awid_i,
  input  logic [N_TARG_PORT*AXI_ADDRESS_W-1:0]   awaddr_i,
  input  logic [N_TARG_PORT*AXI_LEN_W-1:0]       awlen_i,
  input  logic [N_TARG_PORT*AXI_SIZE_W-1:0]      awsize_i,
  input  logic [N_TARG_PORT*AXI_BURST_W-1:0]     awburst_i,
  input  logic [N_TARG_PORT-1:0]                 awlock_i,
  input  logic [N_TARG_PORT*AXI_CACHE_W-1:0]     awcache_i,
  input  logic [N_TARG_PORT*AXI_PROT_W-1:0]      awprot_i,
  input  logic [N_TARG_PORT*AXI_REGION_W-1:0]    awregion_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]      awuser_i,
  input  logic [N_TARG_PORT*AXI_QOS_W-1:0]       awqos_i,
  input  logic [N_TARG_PORT-1:0]                 awvalid_i,
  output logic [N_TARG_PORT-1:0]                 awready_o,

  output logic [AXI_ID_OUT-1:0]                  awid_o,
  output logic [AXI_ADDRESS_W-1:0]               awaddr_o,
  output logic [AXI_LEN_W-1:0]                   awlen_o,
  output logic [AXI_SIZE_W-1:0]                  awsize_o,
  output logic [AXI_BURST_W-1:0]                 awburst_o,
  output logic                                   awlock_o,
  output logic [AXI_CACHE_W-1:0]                 awcache_o,
  output logic [AXI_PROT_W-1:0]                  awprot_o,
  output logic [AXI_REGION_W-1:0]                awregion_o,
  output logic [AXI_USER_W-1:0]                  awuser_o,
  output logic [AXI_QOS_W-1:0]                   awqos_o,
  output logic                                   awvalid_o,
  input  logic                                   awready_i,

  output logic                                   push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]      ID_o,
  input  logic                                   grant_FIFO_ID_i
);

  localparam int PAYLOAD_W = AXI_ID_IN + AXI_ADDRESS_W + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W
                           + 1 + AXI_CACHE_W + AXI_PROT_W + AXI_REGION_W + AXI_USER_W + AXI_QOS_W;

  aw_state_e              state_q, state_d;
  logic [LOG_N_TARG-1:0]  win_q, win_d;
  logic [LOG_N_TARG-1:0]  win_sel;
  logic [LOG_N_TARG-1:0]  arb_idx;
  logic                   arb_valid;
  logic [N_TARG_PORT-1:0] win_oh;
  logic [N_TARG_PORT-1:0] hold_oh;
  logic                   valid_out;
  logic                   handshake;

  logic [N_TARG_PORT*PAYLOAD_W-1:0] payload_all;
  logic [PAYLOAD_W-1:0]             payload_win;
  logic [AXI_ID_IN-1:0]             win_awid;

  for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_pack
    assign payload_all[p*PAYLOAD_W +: PAYLOAD_W] = {
      awid_i[p*AXI_ID_IN +: AXI_ID_IN],
      awaddr_i[p*AXI_ADDRESS_W +: AXI_ADDRESS_W],
      awlen_i[p*AXI_LEN_W +: AXI_LEN_W],
      awsize_i[p*AXI_SIZE_W +: AXI_SIZE_W],
      awburst_i[p*AXI_BURST_W +: AXI_BURST_W],
      awlock_i[p],
      awcache_i[p*AXI_CACHE_W +: AXI_CACHE_W],
      awprot_i[p*AXI_PROT_W +: AXI_PROT_W],
      awregion_i[p*AXI_REGION_W +: AXI_REGION_W],
      awuser_i[p*AXI_USER_W +: AXI_USER_W],
      awqos_i[p*AXI_QOS_W +: AXI_QOS_W]
    };
  end

  axi_aw_rr_arbiter #(
    .N_REQ (N_TARG_PORT),
    .LOG_N (LOG_N_TARG)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (awvalid_i),
    .upd_i       (handshake),
    .upd_idx_i   (win_sel),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  axi_multiplexer #(
    .DATA_WIDTH (PAYLOAD_W),
    .N_IN       (N_TARG_PORT),
    .SEL_WIDTH  (LOG_N_TARG)
  ) u_mux (
    .data_i (payload_all),
    .sel_i  (win_sel),
    .data_o (payload_win)
  );

  assign {win_awid, awaddr_o, awlen_o, awsize_o, awburst_o, awlock_o,
          awcache_o, awprot_o, awregion_o, awuser_o, awqos_o} = payload_win;

  assign hold_oh = {{(N_TARG_PORT-1){1'b0}}, 1'b1} << win_q;
  assign win_oh  = {{(N_TARG_PORT-1){1'b0}}, 1'b1} << win_sel;

  // In HOLD the FIFO slot is already reserved, so grant_FIFO_ID_i is not consulted.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    win_sel   = arb_idx;
    valid_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        win_sel   = arb_idx;
        valid_out = grant_FIFO_ID_i & arb_valid;
        if (valid_out && !awready_i) begin
          state_d = ST_HOLD;
          win_d   = arb_idx;
        end
      end
      ST_HOLD: begin
        win_sel   = win_q;
        valid_out = |(awvalid_i & hold_oh);
        if (valid_out && awready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign handshake = valid_out & awready_i;
  assign awvalid_o = valid_out;
  assign awready_o = handshake ? win_oh : '0;
  assign push_ID_o = handshake;
  assign ID_o      = {win_sel, win_oh};
  assign awid_o    = {win_sel, win_awid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_allocator.sv
// Directed scenarios plus randomized traffic for axi_aw_allocator, checked against a
// transaction-level round-robin model.
module tb_axi_aw_allocator;

  localparam int N   = 7;
  localparam int LG  = 3;
  localparam int IDW = 16;
  localparam int AW  = 32;
  localparam int UW  = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*IDW-1:0] awid_i;
  logic [N*AW-1:0]  awaddr_i;
  logic [N*8-1:0]   awlen_i;
  logic [N*3-1:0]   awsize_i;
  logic [N*2-1:0]   awburst_i;
  logic [N-1:0]     awlock_i;
  logic [N*4-1:0]   awcache_i;
  logic [N*3-1:0]   awprot_i;
  logic [N*4-1:0]   awregion_i;
  logic [N*UW-1:0]  awuser_i;
  logic [N*4-1:0]   awqos_i;
  logic [N-1:0]     awvalid_i;
  logic [N-1:0]     awready_o;
  logic [IDW+LG-1:0] awid_o;
  logic [AW-1:0]    awaddr_o;
  logic [7:0]       awlen_o;
  logic [2:0]       awsize_o;
  logic [1:0]       awburst_o;
  logic             awlock_o;
  logic [3:0]       awcache_o;
  logic [2:0]       awprot_o;
  logic [3:0]       awregion_o;
  logic [UW-1:0]    awuser_o;
  logic [3:0]       awqos_o;
  logic             awvalid_o;
  logic             awready_i;
  logic             push_ID_o;
  logic [LG+N-1:0]  ID_o;
  logic             grant_FIFO_ID_i;

  axi_aw_allocator #(
    .AXI_ADDRESS_W (AW), .AXI_USER_W (UW), .N_TARG_PORT (N),
    .LOG_N_TARG (LG), .AXI_ID_IN (IDW)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .awid_i (awid_i), .awaddr_i (awaddr_i), .awlen_i (awlen_i), .awsize_i (awsize_i),
    .awburst_i (awburst_i), .awlock_i (awlock_i), .awcache_i (awcache_i),
    .awprot_i (awprot_i), .awregion_i (awregion_i), .awuser_i (awuser_i),
    .awqos_i (awqos_i), .awvalid_i (awvalid_i), .awready_o (awready_o),
    .awid_o (awid_o), .awaddr_o (awaddr_o), .awlen_o (awlen_o), .awsize_o (awsize_o),
    .awburst_o (awburst_o), .awlock_o (awlock_o), .awcache_o (awcache_o),
    .awprot_o (awprot_o), .awregion_o (awregion_o), .awuser_o (awuser_o),
    .awqos_o (awqos_o), .awvalid_o (awvalid_o), .awready_i (awready_i),
    .push_ID_o (push_ID_o), .ID_o (ID_o), .grant_FIFO_ID_i (grant_FIFO_ID_i)
  );

  int checks = 0;
  int errors = 0;

  // Model: next port to favour, and the port being held (-1 when none).
  int m_rr   = 0;
  int m_pend = -1;

  logic [N-1:0]      vld;
  logic [LG+N-1:0]   obs_id;
  logic [IDW+LG-1:0] obs_awid;
  logic              obs_push;
  logic              obs_valid;
  int                push_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_payload();
    for (int p = 0; p < N; p++) begin
      awid_i[p*IDW +: IDW]   = IDW'($urandom);
      awaddr_i[p*AW +: AW]   = $urandom;
      awlen_i[p*8 +: 8]      = 8'($urandom);
      awsize_i[p*3 +: 3]     = 3'($urandom);
      awburst_i[p*2 +: 2]    = 2'($urandom);
      awlock_i[p]            = 1'($urandom);
      awcache_i[p*4 +: 4]    = 4'($urandom);
      awprot_i[p*3 +: 3]     = 3'($urandom);
      awregion_i[p*4 +: 4]   = 4'($urandom);
      awuser_i[p*UW +: UW]   = UW'($urandom);
      awqos_i[p*4 +: 4]      = 4'($urandom);
    end
  endtask

  // One clock cycle: inputs already set at the falling edge.
  task automatic step();
    int w;
    logic v;
    logic hs;
    logic [N-1:0] oh;
    awvalid_i = vld;
    w = 0;
    v = 1'b0;
    if (m_pend >= 0) begin
      w = m_pend;
      v = vld[w];
    end else if (grant_FIFO_ID_i) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (!v && vld[k]) begin
          v = 1'b1;
          w = k;
        end
      end
    end
    hs = v && awready_i;
    oh = N'(1) << w;
    #1;
    obs_id    = ID_o;
    obs_awid  = awid_o;
    obs_push  = push_ID_o;
    obs_valid = awvalid_o;
    push_cnt += int'(push_ID_o);
    chk("awvalid", 64'(awvalid_o), 64'(v));
    chk("awready", 64'(awready_o), hs ? 64'(oh) : 64'd0);
    chk("push", 64'(push_ID_o), 64'(hs));
    if (v) begin
      chk("id_o", 64'(ID_o), 64'({LG'(w), oh}));
      chk("awid_o", 64'(awid_o), 64'({LG'(w), awid_i[w*IDW +: IDW]}));
      chk("awaddr", 64'(awaddr_o), 64'(awaddr_i[w*AW +: AW]));
      chk("awlen", 64'(awlen_o), 64'(awlen_i[w*8 +: 8]));
      chk("awuser", 64'(awuser_o), 64'(awuser_i[w*UW +: UW]));
      chk("awqos", 64'(awqos_o), 64'(awqos_i[w*4 +: 4]));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_rr   = 0;
      m_pend = -1;
    end else if (hs) begin
      m_rr   = (w + 1) % N;
      m_pend = -1;
    end else if (v && m_pend < 0) begin
      m_pend = w;
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    vld = '0;
    awvalid_i = '0;
    awready_i = 1'b0;
    grant_FIFO_ID_i = 1'b1;
    randomize_payload();
    @(negedge clk);
    step();
    chk("reset_awvalid", 64'(awvalid_o), 64'd0);
    chk("reset_awready", 64'(awready_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Ports 2 and 5, pointer at 0.
    awready_i = 1'b1;
    vld = 7'b0100100;
    step();
    chk("rr_first_id", 64'(obs_id), 64'({3'd2, 7'b0000100}));
    vld = 7'b0100000;
    step();
    chk("rr_second_id", 64'(obs_id), 64'({3'd5, 7'b0100000}));
    // Pointer now 6: port 6 beats port 0.
    vld = 7'b1000001;
    step();
    chk("wrap_win6", 64'(obs_id), 64'({3'd6, 7'b1000000}));
    vld = 7'b1000000;
    step();
    chk("wrap_again6", 64'(obs_id), 64'({3'd6, 7'b1000000}));
    vld = 7'b0000001;
    step();
    chk("after_wrap0", 64'(obs_id), 64'({3'd0, 7'b0000001}));

    // FIFO full: nothing offered until grant returns.
    grant_FIFO_ID_i = 1'b0;
    vld = 7'b0001000;
    for (int c = 0; c < 3; c++) step();
    chk("nogrant_push", 64'(obs_push), 64'd0);
    grant_FIFO_ID_i = 1'b1;
    step();
    chk("grant_back_id", 64'(obs_id), 64'({3'd3, 7'b0001000}));
    chk("grant_back_push", 64'(obs_push), 64'd1);

    // Port 1 held for 4 cycles, port 0 joins at cycle 2.
    push_cnt = 0;
    awready_i = 1'b0;
    vld = 7'b0000010;
    step();
    step();
    vld = 7'b0000011;
    step();
    step();
    chk("hold_no_push", 64'(push_cnt), 64'd0);
    awready_i = 1'b1;
    step();
    chk("hold_release_id", 64'(obs_id), 64'({3'd1, 7'b0000010}));
    chk("hold_single_push", 64'(push_cnt), 64'd1);
    vld = 7'b0000001;
    step();
    chk("hold_then_p0", 64'(obs_id), 64'({3'd0, 7'b0000001}));

    // Everyone requesting: pointer is 1, so grants run 1..6,0.
    push_cnt = 0;
    vld = 7'b1111111;
    for (int c = 0; c < N; c++) begin
      step();
      chk("all_grantee", 64'(obs_awid[IDW +: LG]), 64'((1 + c) % N));
    end
    chk("all_pushes", 64'(push_cnt), 64'(N));

    // Reset while holding port 4.
    awready_i = 1'b0;
    vld = 7'b0010000;
    step();
    step();
    rst_n = 1'b0;
    vld = '0;
    m_pend = -1;
    m_rr = 0;
    push_cnt = 0;
    step();
    chk("rst_hold_valid", 64'(obs_valid), 64'd0);
    chk("rst_hold_push", 64'(push_cnt), 64'd0);
    rst_n = 1'b1;
    awready_i = 1'b1;
    vld = 7'b0101000;
    step();
    chk("post_rst_id", 64'(obs_id), 64'({3'd3, 7'b0001000}));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      randomize_payload();
      for (int p = 0; p < N; p++) vld[p] = ($urandom_range(0, 99) < 40);
      if (m_pend >= 0) vld[m_pend] = 1'b1;
      awready_i = ($urandom_range(0, 99) < 60);
      grant_FIFO_ID_i = ($urandom_range(0, 99) < 85);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
